mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single data-side port of the unified memory between two requesters: the instruction-cache refill path (I) and the CPU load/store path (D).
- Fixed priority to D, with a starvation guard that periodically forces an I grant.
- Handles one outstanding transaction at a time and has a response watchdog.
- Sits between icache/CPU-LSU and unified_memory, in place of direct wiring.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- STARVE_LIMIT, 4, consecutive D grants with I pending before I is forced; legal range 1..15.
- TIMEOUT_CYCLES, 255, max WAIT cycles before forced completion; legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  I read request; held until i_valid.
- i_addr  in  ADDR_WIDTH  I read address.
- i_rdata  out  DATA_WIDTH  I read data; valid with i_valid.
- i_valid  out  1  I completion pulse, 1 cycle.
- d_req  in  1  D request; held until d_valid.
- d_we  in  1  D write when 1, read when 0.
- d_addr  in  ADDR_WIDTH  D address.
- d_wdata  in  DATA_WIDTH  D write data.
- d_be  in  4  D write byte enables.
- d_rdata  out  DATA_WIDTH  D read data; valid with d_valid.
- d_valid  out  1  D completion pulse, 1 cycle.
- m_req  out  1  memory request strobe, 1 cycle per transaction.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_WIDTH  memory address.
- m_wdata  out  DATA_WIDTH  memory write data.
- m_be  out  4  memory byte enables.
- m_rdata  in  DATA_WIDTH  memory read data.
- m_rvalid  in  1  memory response; acknowledges both reads and writes.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set on watchdog expiry, cleared only by rst.

Behaviour:
- Reset (async, any state): state=IDLE, starve_cnt=0, wd_cnt=0.
  - All outputs 0, including all data/addr outputs.
  - Any in-flight transaction is abandoned; no valid pulse is produced.
- All outputs are registered.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE arbitration (evaluated every IDLE cycle):
  - If starve_cnt==STARVE_LIMIT and i_req: grant I.
  - Else if d_req: grant D.
  - Else if i_req: grant I.
  - Else stay in IDLE.
  - On grant: latch owner, addr, we, wdata, be (I: we=0, be=0) into m_* registers; go to ISSUE.
- starve_cnt:
  - D grant while i_req=1: increment, saturating at STARVE_LIMIT.
  - Any I grant: clear to 0.
  - IDLE cycle with i_req=0: clear to 0.
- ISSUE: m_req=1 for exactly this cycle; m_we/m_addr/m_wdata/m_be stable. Go to WAIT; wd_cnt=0.
- WAIT:
  - m_req=0; m_addr/m_we/m_be/m_wdata held.
  - On m_rvalid: latch m_rdata into the owner's rdata register; go to DONE.
  - Else wd_cnt++. When wd_cnt reaches TIMEOUT_CYCLES: latch 32'hDEADBEEF, set timeout_err, go to DONE.
  - m_rvalid arriving in the same cycle as expiry wins: real data is used, no error.
- DONE:
  - Owner's valid=1 for exactly this cycle; rdata held until that owner's next completion.
  - A write completion also pulses valid; rdata is unchanged.
  - Next state is always IDLE. req inputs are ignored in DONE, so a requester drops req the cycle valid is seen.
- m_rvalid outside WAIT is ignored.
- Latency, uncontended: req seen in IDLE at cycle N -> m_req at N+1 -> valid at N+2+k, where k≥1 is the memory response delay.
  - Minimum is 4 cycles for an immediate response (k=1).
  - Back-to-back issue rate is 1 transaction per 4+ cycles.
- Requester dropping req after grant: the transaction still completes and valid still pulses.
- Simultaneous i_req and d_req with starve_cnt<STARVE_LIMIT: D always wins.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined: adds output ports perf_i_grants [31:0], perf_d_grants [31:0] and perf_conflicts [31:0].
  - perf_i_grants / perf_d_grants: increment on each grant to that requester.
  - perf_conflicts: increments on each IDLE grant cycle with both requests high.
  - All reset to 0 and wrap modulo 2^32.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single read: d_req, d_we=0, d_addr=0x0010_0040; memory returns 0x1234_5678 one cycle after m_req -> m_addr=0x0010_0040, d_valid at 4th cycle, d_rdata=0x1234_5678, m_req high exactly 1 cycle.
- Write: d_we=1, d_wdata=0xCAFEBABE, d_be=4'b0011 -> m_we=1, m_be=4'b0011, m_wdata=0xCAFEBABE during ISSUE; d_valid pulses; d_rdata unchanged.
- Contention: i_req and d_req both held continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; no i_valid/d_valid ever high together.
- Timeout: TIMEOUT_CYCLES=8, m_rvalid never asserted -> i_valid after 8 WAIT cycles, i_rdata=0xDEADBEEF, timeout_err=1 and stays 1; next transaction completes normally.
- Reset mid-operation: rst asserted in WAIT -> all outputs 0 immediately (async), no valid pulse; after release, a new i_req completes normally.
- Stray response: m_rvalid pulsed in IDLE and in ISSUE -> ignored; the later real response in WAIT is the one returned.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares the unified-memory data port between the icache refill
//            path (I) and the CPU load/store path (D). D has fixed priority;
//            a starvation counter forces an I grant after STARVE_LIMIT D
//            grants while I is waiting. One transaction in flight, with a
//            response watchdog that completes a stuck read with 32'hDEADBEEF.
// Options  : define MEM_ARB_PERF_EN to add the perf_* grant/conflict counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction-cache refill requester
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_valid,
    // CPU load/store requester
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [3:0]            d_be,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    // unified memory port
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [3:0]            m_be,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_rvalid,
    // status
    output logic                  busy,
    output logic                  timeout_err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_i_grants,
    output logic [31:0]           perf_d_grants,
    output logic [31:0]           perf_conflicts
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0]            c_starve_limit = 4'(STARVE_LIMIT);
    // the watchdog expires on the TIMEOUT_CYCLES-th WAIT cycle without a response
    localparam logic [15:0]           c_wd_last      = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] c_timeout_data = DATA_WIDTH'(32'hDEADBEEF);

    state_t      r_state;
    logic        r_owner_d;
    logic [3:0]  r_starve_cnt;
    logic [15:0] r_wd_cnt;

    logic        w_force_i;
    logic        w_grant_d;
    logic        w_grant_i;
    logic [3:0]  w_starve_nxt;

    // IDLE arbitration: starved I first, then D, then I
    always_comb begin
        w_force_i = (r_starve_cnt == c_starve_limit) && i_req;
        w_grant_d = !w_force_i && d_req;
        w_grant_i = w_force_i || (!d_req && i_req);
    end

    // Starvation counter update for the current IDLE cycle
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!i_req || w_grant_i) begin
            w_starve_nxt = 4'd0;
        end else if (w_grant_d && (r_starve_cnt != c_starve_limit)) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
        end
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner_d    <= 1'b0;
            r_starve_cnt <= 4'd0;
            r_wd_cnt     <= 16'd0;
            busy         <= 1'b0;
            m_req        <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            m_be         <= 4'd0;
            i_rdata      <= '0;
            i_valid      <= 1'b0;
            d_rdata      <= '0;
            d_valid      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_starve_cnt <= w_starve_nxt;
                    if (w_grant_d) begin
                        r_owner_d <= 1'b1;
                        m_we      <= d_we;
                        m_addr    <= d_addr;
                        m_wdata   <= d_wdata;
                        m_be      <= d_be;
                        m_req     <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end else if (w_grant_i) begin
                        r_owner_d <= 1'b0;
                        m_we      <= 1'b0;
                        m_addr    <= i_addr;
                        m_wdata   <= '0;
                        m_be      <= 4'd0;
                        m_req     <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    m_req    <= 1'b0;
                    r_wd_cnt <= 16'd0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // a response on the expiry cycle takes precedence over the watchdog
                    if (m_rvalid) begin
                        if (r_owner_d) begin
                            if (!m_we) begin
                                d_rdata <= m_rdata;
                            end
                            d_valid <= 1'b1;
                        end else begin
                            i_rdata <= m_rdata;
                            i_valid <= 1'b1;
                        end
                        r_state <= ST_DONE;
                    end else if (r_wd_cnt == c_wd_last) begin
                        if (r_owner_d) begin
                            if (!m_we) begin
                                d_rdata <= c_timeout_data;
                            end
                            d_valid <= 1'b1;
                        end else begin
                            i_rdata <= c_timeout_data;
                            i_valid <= 1'b1;
                        end
                        timeout_err <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    i_valid <= 1'b0;
                    d_valid <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    // Grant and conflict counters, sampled on IDLE grant cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_i_grants  <= 32'd0;
            perf_d_grants  <= 32'd0;
            perf_conflicts <= 32'd0;
        end else if (r_state == ST_IDLE) begin
            if (w_grant_i) begin
                perf_i_grants <= perf_i_grants + 32'd1;
            end
            if (w_grant_d) begin
                perf_d_grants <= perf_d_grants + 32'd1;
            end
            if (i_req && d_req) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
